// File: rtl/sevenseg_pkg.sv
// Shared seven-segment constants (active-low, bit 6 = g .. bit 0 = a) and small helpers
// used by both the hex-to-segment encoder and sevenseg_reader.
package sevenseg_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h04;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // True when exactly one active-low select line is asserted.
    function automatic logic is_one_hot(input logic [DIGITS-1:0] sel_n);
        logic [DIGITS-1:0] v;
        v = ~sel_n;
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] low_index(input logic [DIGITS-1:0] sel_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!sel_n[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational segment-pattern to hex-nibble lookup; unknown patterns give 0 and set invalid.
module sevenseg_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       invalid
);

    // Pattern lookup with an explicit invalid flag for anything outside the hex set
    always_comb begin
        nibble  = 4'h0;
        invalid = 1'b0;
        case (seg_n)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: begin
                nibble  = 4'h0;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Reconstructs a 4-digit hex frame by observing a multiplexed active-low seven-segment bus.
// Optional per-digit invalid-pattern reporting is enabled with SEVENSEG_READER_ERR_EN.
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an_n,
    input  logic [6:0]  seg_n,
    output logic [15:0] data,
    output logic        frame_valid
`ifdef SEVENSEG_READER_ERR_EN
    ,
    output logic [3:0]  err_mask
`endif
);

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [10:0] key_r;
    logic [7:0]  cnt_r;
    state_t      state_r;
    state_t      state_s;
    logic [3:0]  seen_r;
    logic [15:0] shadow_r;
    logic        pend_r;
    logic [15:0] data_r;
    logic        fv_r;

    logic        key_chg_s;
    logic        sel_ok_s;
    logic        capture_s;
    logic [1:0]  dig_s;
    logic [3:0]  seen_next_s;
    logic [3:0]  nib_s;

    assign key_chg_s   = ({an_n, seg_n} != key_r);
    assign sel_ok_s    = is_one_hot(key_r[10:7]);
    assign dig_s       = low_index(key_r[10:7]);
    assign seen_next_s = seen_r | (4'b0001 << dig_s);

`ifdef SEVENSEG_READER_ERR_EN
    logic       inv_s;
    logic [3:0] inv_r;
    logic [3:0] err_r;

    sevenseg_decode u_decode (
        .seg_n   (key_r[6:0]),
        .nibble  (nib_s),
        .invalid (inv_s)
    );

    // Per-digit invalid shadow, published alongside data at frame completion
    always_ff @(posedge clk) begin
        if (reset) begin
            inv_r <= 4'b0000;
            err_r <= 4'b0000;
        end else begin
            if (capture_s) begin
                inv_r[dig_s] <= inv_s;
            end
            if (pend_r) begin
                err_r <= inv_r;
            end
        end
    end

    assign err_mask = err_r;
`else
    logic unused_inv_s;

    sevenseg_decode u_decode (
        .seg_n   (key_r[6:0]),
        .nibble  (nib_s),
        .invalid (unused_inv_s)
    );
`endif

    // Next-state and capture decision; the captured key is the registered one, so a
    // key change in the capture cycle still captures the old digit and re-arms SETTLE
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        if (!sel_ok_s) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_SETTLE;
                ST_SETTLE: begin
                    if (cnt_r == CAP_CNT) begin
                        capture_s = 1'b1;
                        state_s   = key_chg_s ? ST_SETTLE : ST_HELD;
                    end else begin
                        state_s = ST_SETTLE;
                    end
                end
                ST_HELD: begin
                    if (key_chg_s) begin
                        state_s = ST_SETTLE;
                    end else begin
                        state_s = ST_HELD;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Sample key, stability counter, FSM, shadow capture and frame publication
    always_ff @(posedge clk) begin
        if (reset) begin
            key_r    <= 11'h7FF;
            cnt_r    <= 8'd0;
            state_r  <= ST_IDLE;
            seen_r   <= 4'b0000;
            shadow_r <= 16'h0000;
            pend_r   <= 1'b0;
            data_r   <= 16'h0000;
            fv_r     <= 1'b0;
        end else begin
            key_r   <= {an_n, seg_n};
            state_r <= state_s;
            if (!sel_ok_s || key_chg_s) begin
                cnt_r <= 8'd0;
            end else if (cnt_r != 8'hFF) begin
                cnt_r <= cnt_r + 8'd1;
            end
            fv_r   <= pend_r;
            pend_r <= 1'b0;
            if (pend_r) begin
                data_r <= shadow_r;
            end
            if (capture_s) begin
                shadow_r[{dig_s, 2'b00} +: 4] <= nib_s;
                if (seen_next_s == 4'b1111) begin
                    seen_r <= 4'b0000;
                    pend_r <= 1'b1;
                end else begin
                    seen_r <= seen_next_s;
                end
            end
        end
    end

    assign data        = data_r;
    assign frame_valid = fv_r;

endmodule

// File: doc/sevenseg_reader.md
SEVENSEG_READER -- requirements
Module: sevenseg_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive cycles a digit's select and segment pattern must hold unchanged before it is captured; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an_n  input  4  active-low digit select from the multiplexed display bus; bit k low selects digit k.
REQ-005 seg_n  input  7  active-low segment lines; bit 6 = g ... bit 0 = a; same encoding the team's hex-to-segment encoder drives.
REQ-006 data  output  16  last complete frame; nibble k = digit k.
REQ-007 frame_valid  output  1  one-cycle pulse when data has just been updated.
REQ-008 err_mask  output  4  per-digit invalid-pattern flags for the frame in data; exists only with SEVENSEG_READER_ERR_EN.

Function
REQ-009 The block registers {an_n, seg_n} each cycle as the sample key, and a stability counter (8 bits, saturating) resets to 0 whenever the key differs from the previous cycle's key.
REQ-010 FSM states: IDLE (no valid select), SETTLE (counting), HELD (digit captured, waiting for key change).
REQ-011 IDLE -> SETTLE when an_n has exactly one low bit; any state -> IDLE when an_n is all-high or multi-hot, counter cleared.
REQ-012 SETTLE -> HELD when counter reaches STABLE_CYCLES-1 with the key unchanged; that cycle the decoded nibble is written to shadow slot k and seen[k] is set.
REQ-013 HELD -> SETTLE on any key change with a still one-hot an_n; no recapture occurs while in HELD.
REQ-014 Decode table: the 16 hex patterns 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78,0x00,0x10,0x08,0x03,0x46,0x21,0x04,0x0E map to 0..F; any other pattern (including blank 0x7F) decodes to 0 and is marked invalid.
REQ-015 Recapture of a digit already seen in the current frame overwrites its shadow nibble (last value wins).
REQ-016 When the capture that sets the last missing seen bit occurs (seen becomes 4'b1111), on the next edge data <= shadow including that nibble, frame_valid = 1 for exactly one cycle, seen cleared.
REQ-017 data holds its value between frames; frame_valid is 0 in every other cycle.
REQ-018 Capture and key change in the same cycle: the capture completes with the pre-change key; counter restarts from 0 the following cycle.
REQ-019 Capture latency: a digit held steady from cycle t is captured at the edge ending cycle t+STABLE_CYCLES (register stage included).

Reset
REQ-020 On reset: data = 16'h0000, frame_valid = 0, err_mask = 4'b0000, seen = 0, shadow = 0, counter = 0, key register = all-ones, state = IDLE.
REQ-021 Reset asserted mid-frame discards all partially captured digits; the first frame after reset requires all four digits again.

Configuration
REQ-022 Macro SEVENSEG_READER_ERR_EN defined: a shadow invalid bit is captured per digit alongside the nibble and copied to err_mask with data at frame completion.
REQ-023 Macro undefined: err_mask port and invalid-tracking logic are absent; invalid patterns still decode to 0.

Structure
REQ-024 Shared package sevenseg_pkg holds the 16 segment-pattern constants, SEG_BLANK = 7'h7F, and the digit-count constant 4; the team's encoder and this block both use it.
REQ-025 The combinational pattern-to-nibble lookup is a sub-module sevenseg_decode (seg_n in; nibble and invalid out); the FSM, counter and frame assembly stay in sevenseg_reader.

Verification
REQ-026 Drive digits 3..0 = 7'h40,7'h79,7'h24,7'h30 for 6 cycles each, STABLE_CYCLES=4 -> one frame_valid pulse, data = 16'h0123.
REQ-027 Hold digit 0 at 7'h08 for only 3 cycles, then all digits 10 cycles each as 7'h08 -> first partial hold not captured; data = 16'hAAAA after the full pass.
REQ-028 Drive an_n = 4'b0011 (multi-hot) for 20 cycles -> no capture, no frame_valid, FSM stays IDLE.
REQ-029 Digit 2 pattern 7'h7F within an otherwise 7'h12 frame (ERR_EN defined) -> data = 16'h5055, err_mask = 4'b0100.
REQ-030 Assert reset after digits 0..2 captured, then drive full frame 7'h0E x4 -> exactly one frame_valid, data = 16'hFFFF, no frame from the pre-reset partial digits.
REQ-031 Capture digit 1 as 7'h79, then again as 7'h02 before frame completes -> final data nibble 1 = 6.
